// File: rtl/floo_pkg.sv
// Response encodings, merge priority and join FSM states shared by the multicast response join.
package floo_pkg;

  localparam logic [1:0] RespOkay   = 2'd0;
  localparam logic [1:0] RespExOkay = 2'd1;
  localparam logic [1:0] RespSlvErr = 2'd2;
  localparam logic [1:0] RespDecErr = 2'd3;

  typedef enum logic [1:0] {
    JoinIdle    = 2'd0,
    JoinCollect = 2'd1,
    JoinEmit    = 2'd2
  } join_state_e;

  // Severity rank: EXOKAY lowest so it survives only when every response is EXOKAY.
  function automatic logic [1:0] resp_rank(input logic [1:0] r);
    logic [1:0] rank;
    case (r)
      RespExOkay: rank = 2'd0;
      RespOkay:   rank = 2'd1;
      RespSlvErr: rank = 2'd2;
      default:    rank = 2'd3;
    endcase
    return rank;
  endfunction

  function automatic logic [1:0] resp_merge(input logic [1:0] a, input logic [1:0] b);
    return (resp_rank(a) >= resp_rank(b)) ? a : b;
  endfunction

endpackage

// File: rtl/fifo_v3.sv
// Generic FIFO: push ignored when full, pop ignored when empty; data_o shows the head
// combinationally (zero read latency), pointers wrap modulo DEPTH (power of two).
module fifo_v3 #(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic [DATA_WIDTH-1:0]        data_i,
  output logic [DATA_WIDTH-1:0]        data_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH):0]       usage_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]           usage_q, usage_d;
  logic                  do_push, do_pop;

  assign full_o  = (usage_q == (AW+1)'(DEPTH));
  assign empty_o = (usage_q == '0);
  assign usage_o = usage_q;
  assign data_o  = mem_q[rptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    usage_d = usage_q;
    if (do_push) begin
      mem_d[wptr_q] = data_i;
      wptr_d        = wptr_q + 1'b1;
    end
    if (do_pop) begin
      rptr_d = rptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   usage_d = usage_q + 1'b1;
      2'b01:   usage_d = usage_q - 1'b1;
      default: usage_d = usage_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      usage_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      usage_q <= usage_d;
    end
  end

  // Storage needs no reset: it is only observed through valid entries.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/mcast_rsp_join.sv
// Joins per-destination responses of in-order multicasts into one merged response;
// output valid one cycle after the last response, held until out_ready_i; req_ready_o drops only when the queue is full.
module mcast_rsp_join
  import floo_pkg::*;
#(
  parameter int unsigned NumDst         = 4,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  req_valid_i,
  output logic                                  req_ready_o,
  input  logic [NumDst-1:0]                     req_mask_i,
  input  logic [NumDst-1:0]                     rsp_valid_i,
  output logic [NumDst-1:0]                     rsp_ready_o,
  input  logic [NumDst-1:0][1:0]                rsp_resp_i,
  output logic                                  out_valid_o,
  input  logic                                  out_ready_i,
  output logic [1:0]                            out_resp_o,
  output logic [NumDst-1:0]                     out_mask_o,
  output logic [$clog2(MaxOutstanding):0]       outstanding_o
);

  localparam int unsigned CntW = $clog2(MaxOutstanding) + 1;

  join_state_e       state_q, state_d;
  logic [NumDst-1:0] collected_q, collected_d;
  logic [1:0]        acc_q, acc_d;
  logic [NumDst-1:0] head_mask, rsp_hs;
  logic [1:0]        merged;
  logic              q_full, q_empty, q_push, q_pop;
  logic [CntW-1:0]   q_usage;

  assign req_ready_o   = !q_full;
  assign q_push        = req_valid_i && !q_full && (req_mask_i != '0);
  assign outstanding_o = q_usage;

  fifo_v3 #(
    .DATA_WIDTH(NumDst),
    .DEPTH     (MaxOutstanding)
  ) i_mask_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push_i (q_push),
    .pop_i  (q_pop),
    .data_i (req_mask_i),
    .data_o (head_mask),
    .full_o (q_full),
    .empty_o(q_empty),
    .usage_o(q_usage)
  );

  always_comb begin
    state_d     = state_q;
    collected_d = collected_q;
    acc_d       = acc_q;
    rsp_ready_o = '0;
    rsp_hs      = '0;
    merged      = acc_q;
    out_valid_o = 1'b0;
    out_resp_o  = '0;
    out_mask_o  = '0;
    q_pop       = 1'b0;
    case (state_q)
      JoinIdle: begin
        if (!q_empty) state_d = JoinCollect;
      end
      JoinCollect: begin
        rsp_ready_o = head_mask & ~collected_q;
        rsp_hs      = rsp_valid_i & rsp_ready_o;
        // Nothing collected yet: start from the weakest response so EXOKAY can survive.
        merged      = (collected_q == '0) ? RespExOkay : acc_q;
        for (int i = 0; i < int'(NumDst); i++) begin
          if (rsp_hs[i]) merged = resp_merge(merged, rsp_resp_i[i]);
        end
        acc_d       = merged;
        collected_d = collected_q | rsp_hs;
        if (collected_d == head_mask) state_d = JoinEmit;
      end
      JoinEmit: begin
        out_valid_o = 1'b1;
        out_resp_o  = acc_q;
        out_mask_o  = head_mask;
        if (out_ready_i) begin
          q_pop       = 1'b1;
          collected_d = '0;
          acc_d       = '0;
          state_d     = ((q_usage > CntW'(1)) || q_push) ? JoinCollect : JoinIdle;
        end
      end
      default: state_d = JoinIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= JoinIdle;
      collected_q <= '0;
      acc_q       <= '0;
    end else begin
      state_q     <= state_d;
      collected_q <= collected_d;
      acc_q       <= acc_d;
    end
  end

endmodule

// File: tb/tb_mcast_rsp_join.sv
// Directed bench for mcast_rsp_join: hand-computed responses, ordering, full queue and reset.
module tb_mcast_rsp_join;

  localparam int unsigned NumDst = 4;
  localparam int unsigned MaxOutstanding = 4;

  logic                    clk_i = 1'b0;
  logic                    rst_i = 1'b1;
  logic                    req_valid_i = 1'b0;
  logic                    req_ready_o;
  logic [NumDst-1:0]       req_mask_i = '0;
  logic [NumDst-1:0]       rsp_valid_i = '0;
  logic [NumDst-1:0]       rsp_ready_o;
  logic [NumDst-1:0][1:0]  rsp_resp_i = '0;
  logic                    out_valid_o;
  logic                    out_ready_i = 1'b0;
  logic [1:0]              out_resp_o;
  logic [NumDst-1:0]       out_mask_o;
  logic [2:0]              outstanding_o;

  int n_checks = 0;
  int n_errors = 0;

  mcast_rsp_join #(.NumDst(NumDst), .MaxOutstanding(MaxOutstanding)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_mask_i   (req_mask_i),
    .rsp_valid_i  (rsp_valid_i),
    .rsp_ready_o  (rsp_ready_o),
    .rsp_resp_i   (rsp_resp_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_resp_o   (out_resp_o),
    .out_mask_o   (out_mask_o),
    .outstanding_o(outstanding_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_mask(input logic [NumDst-1:0] m);
    req_valid_i = 1'b1;
    req_mask_i  = m;
    tick();
    req_valid_i = 1'b0;
    req_mask_i  = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready_o), 32'd1);
    check({tag, "_rsp_ready"}, 32'(rsp_ready_o), 32'd0);
    check({tag, "_out_valid"}, 32'(out_valid_o), 32'd0);
    check({tag, "_out_resp"},  32'(out_resp_o),  32'd0);
    check({tag, "_out_mask"},  32'(out_mask_o),  32'd0);
    check({tag, "_outstanding"}, 32'(outstanding_o), 32'd0);
  endtask

  // Head mask 4'b0001 in COLLECT: answer dst0 OKAY, then take the output.
  task automatic serve_dst0();
    rsp_valid_i = 4'b0001;
    rsp_resp_i  = '0;
    tick();
    rsp_valid_i = '0;
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
  endtask

  initial begin
    // Reset state
    #1;
    check_reset_outputs("rst");
    tick();
    rst_i = 1'b0;
    tick();

    // Mask 0101: OKAY on dst0 then EXOKAY on dst2 -> OKAY
    push_mask(4'b0101);
    tick();
    check("s1_rsp_ready0", 32'(rsp_ready_o), 32'b0101);
    rsp_valid_i = 4'b0001;
    rsp_resp_i[0] = 2'd0;
    tick();
    rsp_valid_i = '0;
    check("s1_no_early_valid", 32'(out_valid_o), 32'd0);
    check("s1_rsp_ready1", 32'(rsp_ready_o), 32'b0100);
    rsp_valid_i = 4'b0100;
    rsp_resp_i[2] = 2'd1;
    tick();
    rsp_valid_i = '0;
    rsp_resp_i  = '0;
    check("s1_out_valid", 32'(out_valid_o), 32'd1);
    check("s1_out_resp", 32'(out_resp_o), 32'd0);
    check("s1_out_mask", 32'(out_mask_o), 32'b0101);
    tick();
    check("s1_hold_valid", 32'(out_valid_o), 32'd1);
    check("s1_hold_mask", 32'(out_mask_o), 32'b0101);
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    check("s1_pop_valid", 32'(out_valid_o), 32'd0);
    check("s1_pop_fill", 32'(outstanding_o), 32'd0);

    // Mask 1111, all four in one cycle, dst3 SLVERR -> SLVERR
    push_mask(4'b1111);
    tick();
    rsp_valid_i = 4'b1111;
    rsp_resp_i  = {2'd2, 2'd0, 2'd0, 2'd0};
    tick();
    rsp_valid_i = '0;
    rsp_resp_i  = '0;
    check("s2_out_valid", 32'(out_valid_o), 32'd1);
    check("s2_out_resp", 32'(out_resp_o), 32'd2);
    check("s2_out_mask", 32'(out_mask_o), 32'b1111);
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;

    // Mask 0110: DECERR then OKAY across cycles -> DECERR kept
    push_mask(4'b0110);
    tick();
    rsp_valid_i = 4'b0010;
    rsp_resp_i[1] = 2'd3;
    tick();
    rsp_valid_i = 4'b0100;
    rsp_resp_i  = '0;
    tick();
    rsp_valid_i = '0;
    check("s2b_out_resp", 32'(out_resp_o), 32'd3);
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;

    // In-order: 0011 then 0010 with dst1 valid held high
    push_mask(4'b0011);
    push_mask(4'b0010);
    rsp_valid_i = 4'b0011;
    tick();
    rsp_valid_i = 4'b0010;
    check("s3_out_valid", 32'(out_valid_o), 32'd1);
    check("s3_out_mask0", 32'(out_mask_o), 32'b0011);
    check("s3_blocked0", 32'(rsp_ready_o), 32'd0);
    tick();
    check("s3_blocked1", 32'(rsp_ready_o), 32'd0);
    check("s3_fill2", 32'(outstanding_o), 32'd2);
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    check("s3_after_pop_ready", 32'(rsp_ready_o), 32'b0010);
    tick();
    rsp_valid_i = '0;
    check("s3_second_valid", 32'(out_valid_o), 32'd1);
    check("s3_out_mask1", 32'(out_mask_o), 32'b0010);
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    check("s3_drained", 32'(outstanding_o), 32'd0);

    // Full queue: four masks, fifth held off
    for (int i = 0; i < 4; i++) push_mask(4'b0001);
    check("s4_fill4", 32'(outstanding_o), 32'd4);
    check("s4_full_ready", 32'(req_ready_o), 32'd0);
    rsp_valid_i = 4'b0001;
    tick();
    rsp_valid_i = '0;
    req_valid_i = 1'b1;
    req_mask_i  = 4'b0001;
    #1;
    check("s4_fifth_ready", 32'(req_ready_o), 32'd0);
    tick();
    check("s4_fill_held", 32'(outstanding_o), 32'd4);
    check("s4_valid_held", 32'(out_valid_o), 32'd1);
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    check("s4_pop_no_bypass", 32'(outstanding_o), 32'd3);
    check("s4_ready_again", 32'(req_ready_o), 32'd1);
    tick();
    req_valid_i = 1'b0;
    req_mask_i  = '0;
    check("s4_refill", 32'(outstanding_o), 32'd4);
    serve_dst0();
    check("s4_fill3", 32'(outstanding_o), 32'd3);
    rsp_valid_i = 4'b0001;
    tick();
    rsp_valid_i = '0;
    check("s4_emit_fill3", 32'(out_valid_o), 32'd1);
    // Same-cycle push and pop
    out_ready_i = 1'b1;
    req_valid_i = 1'b1;
    req_mask_i  = 4'b0001;
    tick();
    out_ready_i = 1'b0;
    req_valid_i = 1'b0;
    req_mask_i  = '0;
    check("s4_pushpop_fill", 32'(outstanding_o), 32'd3);
    for (int i = 0; i < 3; i++) serve_dst0();
    check("s4_drained", 32'(outstanding_o), 32'd0);

    // Zero mask accepted but not queued
    req_valid_i = 1'b1;
    req_mask_i  = '0;
    #1;
    check("s5_zero_ready", 32'(req_ready_o), 32'd1);
    tick();
    req_valid_i = 1'b0;
    check("s5_fill", 32'(outstanding_o), 32'd0);
    tick();
    tick();
    check("s5_no_out", 32'(out_valid_o), 32'd0);
    check("s5_no_rsp_ready", 32'(rsp_ready_o), 32'd0);

    // Reset mid-transaction
    push_mask(4'b0011);
    tick();
    rsp_valid_i = 4'b0001;
    tick();
    rsp_valid_i = '0;
    check("s6_partial_fill", 32'(outstanding_o), 32'd1);
    rst_i = 1'b1;
    #1;
    check_reset_outputs("s6_rst");
    tick();
    rst_i = 1'b0;
    tick();
    tick();
    check("s6_no_emit", 32'(out_valid_o), 32'd0);
    check("s6_fill_after", 32'(outstanding_o), 32'd0);
    push_mask(4'b0001);
    tick();
    rsp_valid_i = 4'b0001;
    rsp_resp_i[0] = 2'd1;
    tick();
    rsp_valid_i = '0;
    rsp_resp_i  = '0;
    check("s6_new_valid", 32'(out_valid_o), 32'd1);
    check("s6_new_resp", 32'(out_resp_o), 32'd1);
    check("s6_new_mask", 32'(out_mask_o), 32'b0001);
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    check("s6_done", 32'(out_valid_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
